// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel/line position and data-enable from a VGA sync stream,
// measures line/frame periods, locks to the expected timing and counts timing errors.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 1344,
    parameter int V_TOTAL     = 806,
    parameter int MISS_LIMIT  = 2,
    parameter int WDOG_CYCLES = 2688
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        de_out,
    output logic        locked,
    output logic [11:0] meas_htotal,
    output logic [10:0] meas_vtotal,
    output logic        err_pulse,
    output logic [7:0]  err_cnt
);
    localparam logic [1:0]  SEARCH  = 2'd0;
    localparam logic [1:0]  MEASURE = 2'd1;
    localparam logic [1:0]  LOCKED  = 2'd2;
    localparam logic [11:0] HT = 12'(H_TOTAL);
    localparam logic [10:0] VT = 11'(V_TOTAL);
    localparam logic [11:0] WD = 12'(WDOG_CYCLES);
    localparam logic [7:0]  ML = 8'(MISS_LIMIT);

    logic [3:0]  in_q, dly_q;
    logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d, ln_cnt_q, ln_cnt_d;
    logic [10:0] meas_v_q, meas_v_d;
    logic [11:0] clk_cnt_q, clk_cnt_d, meas_h_q, meas_h_d;
    logic [7:0]  err_cnt_q, err_cnt_d, miss_q, miss_d;
    logic [1:0]  state_q, state_d;
    logic        de_q, de_d, err_q, err_d, fbad_q, fbad_d;
    logic        hs_rise, vs_rise, hb_fall, vb_fall, h_bad, v_bad, frame_bad, wdog;

    // in_q/dly_q bit order: {hsync, vsync, hblnk, vblnk}
    assign hs_rise   = in_q[3] & ~dly_q[3];
    assign vs_rise   = in_q[2] & ~dly_q[2];
    assign hb_fall   = ~in_q[1] & dly_q[1];
    assign vb_fall   = ~in_q[0] & dly_q[0];
    assign h_bad     = hs_rise & (clk_cnt_q != HT);
    assign v_bad     = vs_rise & (ln_cnt_q != VT);
    assign frame_bad = fbad_q | v_bad;
    assign wdog      = ~hs_rise & (clk_cnt_q >= WD);

    always_comb begin
        hcount_d  = hb_fall ? 11'd0 : (&hcount_q ? hcount_q : hcount_q + 11'd1);
        vcount_d  = vb_fall ? 11'd0 : ((hb_fall & ~&vcount_q) ? vcount_q + 11'd1 : vcount_q);
        de_d      = ~in_q[1] & ~in_q[0];
        clk_cnt_d = hs_rise ? 12'd1 : (&clk_cnt_q ? clk_cnt_q : clk_cnt_q + 12'd1);
        // an hsync rise coincident with vsync rise belongs to the new frame
        ln_cnt_d  = vs_rise ? {10'd0, hs_rise} : ((hs_rise & ~&ln_cnt_q) ? ln_cnt_q + 11'd1 : ln_cnt_q);
        meas_h_d  = hs_rise ? clk_cnt_q : meas_h_q;
        meas_v_d  = vs_rise ? ln_cnt_q : meas_v_q;
        fbad_d    = vs_rise ? h_bad : fbad_q | h_bad;
        state_d   = state_q;
        miss_d    = miss_q;
        err_d     = 1'b0;
        if (wdog) begin
            state_d = SEARCH;
            miss_d  = 8'd0;
            err_d   = state_q == LOCKED;
        end else begin
            err_d = (state_q == LOCKED) & (h_bad | v_bad);
            if (vs_rise) begin
                if (state_q == SEARCH) state_d = MEASURE;
                else if (state_q == MEASURE) state_d = frame_bad ? MEASURE : LOCKED;
                else begin
                    miss_d = frame_bad ? miss_q + 8'd1 : 8'd0;
                    if (miss_d >= ML) begin
                        state_d = SEARCH;
                        miss_d  = 8'd0;
                    end
                end
            end
        end
        err_cnt_d = (err_d & ~&err_cnt_q) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= '0;
            dly_q     <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            de_q      <= 1'b0;
            clk_cnt_q <= '0;
            ln_cnt_q  <= '0;
            meas_h_q  <= '0;
            meas_v_q  <= '0;
            fbad_q    <= 1'b0;
            state_q   <= SEARCH;
            miss_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            in_q      <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
            dly_q     <= in_q;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            de_q      <= de_d;
            clk_cnt_q <= clk_cnt_d;
            ln_cnt_q  <= ln_cnt_d;
            meas_h_q  <= meas_h_d;
            meas_v_q  <= meas_v_d;
            fbad_q    <= fbad_d;
            state_q   <= state_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign hcount_out  = hcount_q;
    assign vcount_out  = vcount_q;
    assign de_out      = de_q;
    assign locked      = state_q == LOCKED;
    assign meas_htotal = meas_h_q;
    assign meas_vtotal = meas_v_q;
    assign err_pulse   = err_q;
    assign err_cnt     = err_cnt_q;
endmodule
